xdma_cfg_frame_receiver: RTL and testbench
==========================================

Name: xdma_cfg_frame_receiver

Overview:
- Receive side of the inter-cluster configuration frame protocol: accepts 512-bit cfg frames arriving from a remote cluster's XDMA (FromRemoteCfg path).
- Parses the first frame (type, frame count, ID, reader/writer addresses, payload head) and reassembles continuation frames into one flat descriptor.
- Presents the assembled descriptor to the local XDMA controller over a valid/ready handshake.
- Malformed sequences are detected and discarded.

Parameters:
- AxiDataWidth, 512, frame width in bits.
- AddrWidth, 48, address field width.
- DMAIdWidth, 4, DMA ID field width.
- MaxFrames, 4, maximum total frames per config (first frame included); range 1..15.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- frame_data_i  input  512  incoming cfg frame
- frame_valid_i  input  1  frame valid
- frame_ready_o  output  1  frame accepted when valid&ready
- cfg_valid_o  output  1  assembled descriptor valid
- cfg_ready_i  input  1  consumer accepts descriptor
- cfg_dma_id_o  output  4  DMA ID
- cfg_dma_type_o  output  1  0 = read, 1 = write
- cfg_reader_addr_o  output  48  reader address
- cfg_writer_addr_o  output  48  writer address
- cfg_frame_length_o  output  4  total frames received
- cfg_payload_o  output  407+(MaxFrames-1)*507  concatenated payload; first-frame payload in LSBs
- error_o  output  1  single-cycle pulse on protocol error

Behaviour:
- Reset: asynchronous, active-low. State IDLE; all output registers 0; frame_ready_o=0 during reset, 1 after release; error_o=0.
- First-frame bit map (LSB first):
  - dma_type [0]
  - frame_length [4:1]
  - dma_id [8:5]
  - reader_addr [56:9]
  - writer_addr [104:57]
  - payload [511:105] (407 bits)
- Continuation-frame bit map (LSB first):
  - dma_id [3:0]
  - dma_type [4]
  - payload [511:5] (507 bits)
- frame_ready_o = 1 in IDLE, COLLECT and DROP; 0 in OUTPUT. Combinational from state only; it must not depend on frame_valid_i.
- IDLE, on frame accept:
  - Latch header fields; write the 407-bit slice into payload[406:0]; zero all other payload bits; frame counter = 1.
  - frame_length == 0: error_o pulse next cycle, stay IDLE, no output.
  - frame_length > MaxFrames: error_o pulse, go to DROP with remaining = frame_length-1.
  - frame_length == 1: go to OUTPUT; cfg_valid_o high the cycle after acceptance.
  - Otherwise: go to COLLECT.
- COLLECT, on frame accept:
  - dma_id mismatch with latched ID: frame discarded, error_o pulse, counter unchanged, remain COLLECT.
  - dma_type mismatch is ignored.
  - Match: write payload into slot k, bits [407+(k-1)*507 +: 507] with k = counter; increment counter.
  - When counter reaches frame_length, go to OUTPUT (cfg_valid_o high the next cycle).
- DROP: accept and discard frames regardless of content, decrementing remaining; go to IDLE on the frame that makes remaining 0.
- OUTPUT:
  - All cfg_* outputs held stable while cfg_valid_o=1 && !cfg_ready_i.
  - On cfg_valid_o && cfg_ready_i: go to IDLE; frame_ready_o=1 the following cycle.
  - Minimum gap between consecutive descriptors: 1 bubble cycle.
- Latency: single-frame config, accept at cycle t gives cfg_valid_o at t+1. N-frame back-to-back: cfg_valid_o one cycle after the Nth frame is accepted.
- Outputs are registered; no combinational path from frame_data_i to any cfg_* output.
- cfg_frame_length_o = latched frame_length.
- Reset asserted mid-operation: immediately return to IDLE; partial config and pending descriptor are lost; outputs cleared.
- error_o: one cycle per error event; never asserted while in OUTPUT.

Test Plan:
- Single frame, type=1, len=1, id=0x3, reader=0x1000, writer=0x2000, payload head 0xABCD: accepted t0 → cfg_valid_o at t0+1 with those fields; payload[15:0]=0xABCD; rest of payload 0.
- Four-frame config, id=0x5, continuation payloads 0x11/0x22/0x33 held with cfg_ready_i=0 for 5 cycles: frame_ready_o=0 and outputs stable; bits [407+:8]=0x11, [914+:8]=0x22, [1421+:8]=0x33; descriptor released on ready.
- Three-frame config with an intervening continuation carrying id=0x9 (expected 0x2): error_o one pulse; mismatched frame ignored; descriptor completes after two valid continuations.
- frame_length=6 (>MaxFrames=4): error_o pulse; next 5 frames accepted and discarded; no cfg_valid_o; the next legal config is then processed normally.
- frame_length=0 → error_o pulse, stays IDLE. Separately, rst_ni low during COLLECT after 2 of 3 frames → outputs 0, IDLE; a new 1-frame config then completes correctly.

Source files
------------

// File: rtl/xdma_cfg_frame_receiver.sv
// rtl/xdma_cfg_frame_receiver.sv - reassembles inter-cluster cfg frames into one XDMA descriptor
//
// Receives 512-bit configuration frames from a remote cluster, parses the
// first (header) frame, appends continuation-frame payloads, and hands the
// flat descriptor to the local XDMA controller over valid/ready.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   frame_data_i/valid/ready  incoming frame stream
//   cfg_valid_o/cfg_ready_i   descriptor handshake
//   cfg_*_o                   assembled descriptor fields (registered)
//   error_o                   one-cycle pulse per protocol error
module xdma_cfg_frame_receiver #(
    parameter int AxiDataWidth = 512,
    parameter int AddrWidth    = 48,
    parameter int DMAIdWidth   = 4,
    parameter int MaxFrames    = 4,
    localparam int PayloadWidth = 407 + (MaxFrames - 1) * 507
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AxiDataWidth-1:0] frame_data_i,
    input  logic                    frame_valid_i,
    output logic                    frame_ready_o,
    output logic                    cfg_valid_o,
    input  logic                    cfg_ready_i,
    output logic [DMAIdWidth-1:0]   cfg_dma_id_o,
    output logic                    cfg_dma_type_o,
    output logic [AddrWidth-1:0]    cfg_reader_addr_o,
    output logic [AddrWidth-1:0]    cfg_writer_addr_o,
    output logic [3:0]              cfg_frame_length_o,
    output logic [PayloadWidth-1:0] cfg_payload_o,
    output logic                    error_o
);

    localparam logic [3:0] MaxLen = 4'(MaxFrames);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       out_of_reset_q;
    logic [3:0] count_q;
    logic [3:0] remaining_q;
    logic       error_d;
    logic       accept;
    logic [3:0] hdr_len;
    logic       id_match;

    assign accept   = frame_valid_i && frame_ready_o;
    assign hdr_len  = frame_data_i[4:1];
    assign id_match = (frame_data_i[3:0] == cfg_dma_id_o);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            out_of_reset_q <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_of_reset_q <= 1'b1;
            error_o        <= error_d;
        end
    end

    // Next-state and error-event logic
    always_comb begin
        state_d = state_q;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_len == 4'd0) begin
                        error_d = 1'b1;
                    end else if (hdr_len > MaxLen) begin
                        error_d = 1'b1;
                        state_d = DROP;
                    end else if (hdr_len == 4'd1) begin
                        state_d = OUTPUT;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (!id_match) begin
                        error_d = 1'b1;
                    end else if (count_q + 4'd1 == cfg_frame_length_o) begin
                        state_d = OUTPUT;
                    end
                end
            end
            DROP: begin
                if (accept && remaining_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            OUTPUT: begin
                if (cfg_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only; ready is held low until the first
    // clock after reset release.
    always_comb begin
        frame_ready_o = out_of_reset_q && (state_q != OUTPUT);
        cfg_valid_o   = (state_q == OUTPUT);
    end

    // Descriptor assembly registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_dma_id_o       <= '0;
            cfg_dma_type_o     <= 1'b0;
            cfg_reader_addr_o  <= '0;
            cfg_writer_addr_o  <= '0;
            cfg_frame_length_o <= '0;
            cfg_payload_o      <= '0;
            count_q            <= '0;
            remaining_q        <= '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    cfg_dma_type_o     <= frame_data_i[0];
                    cfg_frame_length_o <= frame_data_i[4:1];
                    cfg_dma_id_o       <= frame_data_i[8:5];
                    cfg_reader_addr_o  <= frame_data_i[56:9];
                    cfg_writer_addr_o  <= frame_data_i[104:57];
                    cfg_payload_o      <= PayloadWidth'(frame_data_i[511:105]);
                    count_q            <= 4'd1;
                    remaining_q        <= hdr_len - 4'd1;
                end
                COLLECT: begin
                    if (id_match) begin
                        // Slot k (k = frames already held) lands right above
                        // the 407-bit head and the k-1 earlier 507-bit slots.
                        for (int s = 1; s < MaxFrames; s++) begin
                            if (count_q == 4'(s)) begin
                                cfg_payload_o[407 + (s - 1) * 507 +: 507] <= frame_data_i[511:5];
                            end
                        end
                        count_q <= count_q + 4'd1;
                    end
                end
                DROP: begin
                    remaining_q <= remaining_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xdma_cfg_frame_receiver.sv
// tb/tb_xdma_cfg_frame_receiver.sv - self-checking bench for xdma_cfg_frame_receiver
module tb_xdma_cfg_frame_receiver;

    localparam int MAXF = 4;
    localparam int PW   = 407 + (MAXF - 1) * 507;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [511:0]  fdata;
    logic          fvalid;
    logic          frame_ready;
    logic          cfg_valid;
    logic          cready;
    logic [3:0]    cfg_id;
    logic          cfg_type;
    logic [47:0]   cfg_ra;
    logic [47:0]   cfg_wa;
    logic [3:0]    cfg_len;
    logic [PW-1:0] cfg_pl;
    logic          error;

    always #5 clk = ~clk;

    xdma_cfg_frame_receiver #(.MaxFrames(MAXF)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .frame_data_i       (fdata),
        .frame_valid_i      (fvalid),
        .frame_ready_o      (frame_ready),
        .cfg_valid_o        (cfg_valid),
        .cfg_ready_i        (cready),
        .cfg_dma_id_o       (cfg_id),
        .cfg_dma_type_o     (cfg_type),
        .cfg_reader_addr_o  (cfg_ra),
        .cfg_writer_addr_o  (cfg_wa),
        .cfg_frame_length_o (cfg_len),
        .cfg_payload_o      (cfg_pl),
        .error_o            (error)
    );

    typedef struct {
        logic [3:0]    id;
        logic          typ;
        logic [47:0]   ra;
        logic [47:0]   wa;
        logic [3:0]    len;
        logic [PW-1:0] pl;
    } desc_t;

    desc_t got_q[$];
    desc_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    err_cnt = 0;
    int    exp_err = 0;
    bit    rand_rdy = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] first_frame(input logic typ, input logic [3:0] len,
            input logic [3:0] id, input logic [47:0] ra, input logic [47:0] wa,
            input logic [406:0] pl);
        return {pl, wa, ra, id, len, typ};
    endfunction

    function automatic logic [511:0] cont_frame(input logic [3:0] id, input logic typ,
            input logic [506:0] pl);
        return {pl, typ, id};
    endfunction

    // Reference model: tracks only "frames still owed" and "frames to skip",
    // keeps payload pieces in a list and concatenates them when complete.
    int           m_need = 0;
    int           m_skip = 0;
    desc_t        m_hdr;
    logic [406:0] m_head;
    logic [506:0] m_pieces[$];

    task automatic model_complete();
        desc_t d;
        d = m_hdr;
        d.pl = '0;
        d.pl[406:0] = m_head;
        foreach (m_pieces[i]) d.pl = d.pl | (PW'(m_pieces[i]) << (407 + 507 * i));
        exp_q.push_back(d);
    endtask

    task automatic model_frame(input logic [511:0] f);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_need == 0) begin
            m_hdr.typ = f[0];
            m_hdr.len = f[4:1];
            m_hdr.id  = f[8:5];
            m_hdr.ra  = f[56:9];
            m_hdr.wa  = f[104:57];
            m_head    = f[511:105];
            m_pieces.delete();
            if (m_hdr.len == 0) begin
                exp_err++;
            end else if (int'(m_hdr.len) > MAXF) begin
                exp_err++;
                m_skip = int'(m_hdr.len) - 1;
            end else begin
                m_need = int'(m_hdr.len) - 1;
                if (m_need == 0) model_complete();
            end
        end else if (f[3:0] != m_hdr.id) begin
            exp_err++;
        end else begin
            m_pieces.push_back(f[511:5]);
            m_need--;
            if (m_need == 0) model_complete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [511:0] f);
        bit ok;
        ok = 0;
        fdata  = f;
        fvalid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (frame_ready) ok = 1;
            step();
        end
        fvalid = 1'b0;
        if (ok) model_frame(f);
        else check("send_timeout", 0, 1);
    endtask

    task automatic check_desc(input string tag, input desc_t g, input desc_t e);
        check({tag, "_id"}, g.id, e.id);
        check({tag, "_type"}, g.typ, e.typ);
        check({tag, "_raddr"}, g.ra, e.ra);
        check({tag, "_waddr"}, g.wa, e.wa);
        check({tag, "_len"}, g.len, e.len);
        check({tag, "_pl0"}, g.pl[406:0], e.pl[406:0]);
        for (int s = 1; s < MAXF; s++)
            check({tag, "_pl", $sformatf("%0d", s)}, g.pl[407 + (s-1)*507 +: 507], e.pl[407 + (s-1)*507 +: 507]);
    endtask

    // Monitor: captures handshaken descriptors, counts error pulses and
    // verifies outputs hold while stalled.
    logic [2047:0] prev_snap;
    bit            prev_hold = 0;
    always @(negedge clk) begin
        logic [2047:0] snap;
        desc_t d;
        snap = 2048'({cfg_id, cfg_type, cfg_ra, cfg_wa, cfg_len, cfg_pl});
        if (prev_hold && rst_n) check("hold_stable", snap == prev_snap, 1);
        prev_snap = snap;
        prev_hold = rst_n && cfg_valid && !cready;
        if (error) begin
            err_cnt++;
            check("err_in_output", cfg_valid, 0);
        end
        if (rst_n && cfg_valid && cready) begin
            d.id = cfg_id; d.typ = cfg_type; d.ra = cfg_ra; d.wa = cfg_wa;
            d.len = cfg_len; d.pl = cfg_pl;
            got_q.push_back(d);
        end
    end

    initial begin
        forever begin
            step();
            if (rand_rdy) cready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [406:0] hp;
        logic [506:0] cp;
        int           len;
        logic [3:0]   id;
        desc_t        g, e;

        rst_n = 1'b0; fvalid = 1'b0; fdata = '0; cready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_error", error, 0);
        check("rst_id", cfg_id, 0);
        check("rst_pl0", cfg_pl[406:0], 0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_ready", frame_ready, 1);
        step();

        // Single-frame config: valid one cycle after acceptance
        cready = 1'b1;
        hp = 407'hABCD;
        send_frame(first_frame(1'b1, 4'd1, 4'h3, 48'h1000, 48'h2000, hp));
        @(negedge clk);
        check("tp1_valid", cfg_valid, 1);
        check("tp1_id", cfg_id, 4'h3);
        check("tp1_type", cfg_type, 1);
        check("tp1_raddr", cfg_ra, 48'h1000);
        check("tp1_waddr", cfg_wa, 48'h2000);
        check("tp1_len", cfg_len, 1);
        check("tp1_pl_lo", cfg_pl[15:0], 16'hABCD);
        check("tp1_pl_head_rest", cfg_pl[406:16], 0);
        for (int s = 1; s < MAXF; s++)
            check("tp1_pl_slot_zero", cfg_pl[407 + (s-1)*507 +: 507], 0);
        @(negedge clk);
        check("tp1_bubble_valid", cfg_valid, 0);
        check("tp1_bubble_ready", frame_ready, 1);
        step();

        // Four frames, held under backpressure
        cready = 1'b0;
        hp = rnd512();
        send_frame(first_frame(1'b0, 4'd4, 4'h5, 48'hAAAA, 48'hBBBB, hp));
        send_frame(cont_frame(4'h5, 1'b0, 507'h11));
        send_frame(cont_frame(4'h5, 1'b1, 507'h22));
        send_frame(cont_frame(4'h5, 1'b0, 507'h33));
        @(negedge clk);
        check("tp2_valid", cfg_valid, 1);
        check("tp2_s1", cfg_pl[407 +: 8], 8'h11);
        check("tp2_s2", cfg_pl[914 +: 8], 8'h22);
        check("tp2_s3", cfg_pl[1421 +: 8], 8'h33);
        repeat (5) begin
            @(negedge clk);
            check("tp2_ready_low", frame_ready, 0);
            check("tp2_valid_held", cfg_valid, 1);
        end
        step();
        cready = 1'b1;
        step();
        @(negedge clk);
        check("tp2_released", cfg_valid, 0);
        step();

        // Three frames with a foreign-ID continuation in between
        hp = rnd512();
        send_frame(first_frame(1'b1, 4'd3, 4'h2, 48'h1, 48'h2, hp));
        cp = rnd512();
        send_frame(cont_frame(4'h2, 1'b1, cp));
        send_frame(cont_frame(4'h9, 1'b1, 507'h5A5A));
        @(negedge clk);
        check("tp3_err_pulse", error, 1);
        @(negedge clk);
        check("tp3_err_single", error, 0);
        check("tp3_no_valid_yet", cfg_valid, 0);
        step();
        cp = rnd512();
        send_frame(cont_frame(4'h2, 1'b0, cp));
        @(negedge clk);
        check("tp3_valid", cfg_valid, 1);
        step();

        // Over-long config is dropped, then a legal one goes through
        send_frame(first_frame(1'b0, 4'd6, 4'h7, 48'h0, 48'h0, 407'h1));
        @(negedge clk);
        check("tp4_err_pulse", error, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            send_frame(rnd512());
            check("tp4_drop_no_valid", cfg_valid, 0);
        end
        hp = rnd512(); cp = rnd512();
        send_frame(first_frame(1'b1, 4'd2, 4'h7, 48'h77, 48'h88, hp));
        send_frame(cont_frame(4'h7, 1'b1, cp));
        @(negedge clk);
        check("tp4_legal_valid", cfg_valid, 1);
        step();

        // Zero-length header
        send_frame(first_frame(1'b0, 4'd0, 4'h1, 48'h0, 48'h0, 407'h0));
        @(negedge clk);
        check("tp5_err_pulse", error, 1);
        check("tp5_idle_ready", frame_ready, 1);
        check("tp5_no_valid", cfg_valid, 0);
        step();

        // Reset in the middle of a three-frame collect
        send_frame(first_frame(1'b1, 4'd3, 4'h1, 48'h123, 48'h456, 407'h9));
        send_frame(cont_frame(4'h1, 1'b1, 507'h8));
        rst_n = 1'b0;
        m_need = 0;
        m_skip = 0;
        #1;
        check("rst_mid_ready", frame_ready, 0);
        check("rst_mid_valid", cfg_valid, 0);
        check("rst_mid_id", cfg_id, 0);
        check("rst_mid_raddr", cfg_ra, 0);
        check("rst_mid_pl0", cfg_pl[406:0], 0);
        step();
        rst_n = 1'b1;
        step();
        hp = 407'h4242;
        send_frame(first_frame(1'b0, 4'd1, 4'hC, 48'hCAFE, 48'hBEEF, hp));
        @(negedge clk);
        check("rst_new_valid", cfg_valid, 1);
        check("rst_new_id", cfg_id, 4'hC);
        check("rst_new_pl0", cfg_pl[406:0], 407'h4242);
        step();

        // Randomized traffic with random backpressure
        rand_rdy = 1;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 7);
            id  = 4'($urandom);
            hp  = rnd512();
            send_frame(first_frame(1'($urandom), 4'(len), id, 48'({$urandom, $urandom}),
                                   48'({$urandom, $urandom}), hp));
            if (len > MAXF) begin
                for (int k = 1; k < len; k++) send_frame(rnd512());
            end else begin
                for (int k = 1; k < len; k++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        cp = rnd512();
                        send_frame(cont_frame(id ^ 4'($urandom_range(1, 15)), 1'($urandom), cp));
                    end
                    cp = rnd512();
                    send_frame(cont_frame(id, 1'($urandom), cp));
                end
            end
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rdy = 0;
        step();
        cready = 1'b1;
        begin
            bit drained;
            drained = 0;
            for (int i = 0; i < 20 && !drained; i++) begin
                @(negedge clk);
                if (!cfg_valid) drained = 1;
            end
            check("drain", drained, 1);
        end
        repeat (3) step();

        check("desc_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            g = got_q[i];
            e = exp_q[i];
            check_desc($sformatf("desc%0d", i), g, e);
        end
        check("err_count", err_cnt, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
